// File: rtl/neuron_accumulator.sv
// neuron_accumulator: sums a frame of N_TERMS signed products into one
// neuron pre-activation value. Valid/ready flow control sits on both sides.
// A completed sum is held until the consumer takes it, and accumulator
// overflow is flagged for the frame being presented.
// Optional feature: define NEURON_ACC_SAT_EN to saturate on overflow
// instead of wrapping.
module neuron_accumulator #(
    parameter int PROD_W  = 26,
    parameter int ACC_W   = 32,
    parameter int N_TERMS = 784,
    parameter int CNT_W   = 10
) (
    input  logic              clk,
    input  logic              GlobalReset,
    input  logic [PROD_W-1:0] ProductPort,
    input  logic              ProductValid,
    output logic              ProductReady,
    input  logic              Clear,
    output logic [ACC_W-1:0]  SumOut,
    output logic              SumValid,
    input  logic              SumReady,
    output logic              Overflow,
    output logic [CNT_W-1:0]  TermCount
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(N_TERMS - 1);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   term_count_q, term_count_d;
    logic               sticky_q, sticky_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic               sum_valid_q, sum_valid_d;
    logic               overflow_q, overflow_d;

    logic [ACC_W-1:0]   product_ext;
    logic [ACC_W-1:0]   add_raw;
    logic               add_ovf;
    logic [ACC_W-1:0]   add_result;

    // Sign-extend the incoming product, add it to the running sum and
    // detect signed overflow (equal operand signs, different result sign).
    always_comb begin
        product_ext = ACC_W'($signed(ProductPort));
        add_raw     = acc_q + product_ext;
        add_ovf     = (acc_q[ACC_W-1] == product_ext[ACC_W-1]) &&
                      (add_raw[ACC_W-1] != acc_q[ACC_W-1]);
`ifdef NEURON_ACC_SAT_EN
        if (add_ovf) begin
            add_result = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end else begin
            add_result = add_raw;
        end
`else
        add_result = add_raw;
`endif
    end

    // Next-state logic: accumulate in ACCUM, present and hold the sum in HOLD.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        term_count_d = term_count_q;
        sticky_d     = sticky_q;
        sum_d        = sum_q;
        sum_valid_d  = sum_valid_q;
        overflow_d   = overflow_q;

        case (state_q)
            ACCUM: begin
                if (Clear) begin
                    acc_d        = '0;
                    term_count_d = '0;
                    sticky_d     = 1'b0;
                end else if (ProductValid) begin
                    if (term_count_q == LAST_TERM) begin
                        sum_d        = add_result;
                        sum_valid_d  = 1'b1;
                        overflow_d   = sticky_q | add_ovf;
                        acc_d        = '0;
                        term_count_d = '0;
                        sticky_d     = 1'b0;
                        state_d      = HOLD;
                    end else begin
                        acc_d        = add_result;
                        term_count_d = term_count_q + CNT_W'(1);
                        sticky_d     = sticky_q | add_ovf;
                    end
                end
            end
            HOLD: begin
                if (SumReady) begin
                    sum_valid_d = 1'b0;
                    overflow_d  = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial or pending sum.
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            state_q      <= ACCUM;
            acc_q        <= '0;
            term_count_q <= '0;
            sticky_q     <= 1'b0;
            sum_q        <= '0;
            sum_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            term_count_q <= term_count_d;
            sticky_q     <= sticky_d;
            sum_q        <= sum_d;
            sum_valid_q  <= sum_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    // Outputs: ready is a pure decode of the state register.
    always_comb begin
        ProductReady = (state_q == ACCUM);
        SumOut       = sum_q;
        SumValid     = sum_valid_q;
        Overflow     = overflow_q;
        TermCount    = term_count_q;
    end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Testbench for neuron_accumulator: table-driven vectors, hand-written
// corner-case sequences and a randomized run against a reference model.
module tb_neuron_accumulator;

    localparam int PROD_W  = 12;
    localparam int ACC_W   = 13;
    localparam int N_TERMS = 4;
    localparam int CNT_W   = 3;
    localparam longint ACC_MAX = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W - 1));
    localparam longint ACC_SPAN = longint'(1) <<< ACC_W;

    logic              clk;
    logic              GlobalReset;
    logic [PROD_W-1:0] ProductPort;
    logic              ProductValid;
    logic              ProductReady;
    logic              Clear;
    logic [ACC_W-1:0]  SumOut;
    logic              SumValid;
    logic              SumReady;
    logic              Overflow;
    logic [CNT_W-1:0]  TermCount;

    int n_compared = 0;
    int n_failed   = 0;

    // Reference model: frame-level arithmetic on wide integers.
    longint m_acc;
    int     m_cnt;
    bit     m_sticky;
    bit     m_hold;
    longint m_sum;
    bit     m_ovf;

    typedef struct {
        bit v;
        int p;
        bit c;
        bit r;
        bit e_ready;
        bit e_valid;
        int e_sum;
        bit e_ovf;
        int e_cnt;
    } vec_t;

    vec_t vecs[$];

    neuron_accumulator #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .N_TERMS(N_TERMS),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .ProductPort (ProductPort),
        .ProductValid(ProductValid),
        .ProductReady(ProductReady),
        .Clear       (Clear),
        .SumOut      (SumOut),
        .SumValid    (SumValid),
        .SumReady    (SumReady),
        .Overflow    (Overflow),
        .TermCount   (TermCount)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic modelReset();
        m_acc    = 0;
        m_cnt    = 0;
        m_sticky = 0;
        m_hold   = 0;
        m_sum    = 0;
        m_ovf    = 0;
    endtask

    // One clock edge of the reference model given the inputs seen at that edge.
    task automatic modelStep(input bit v, input int p, input bit c, input bit r);
        longint full;
        longint next;
        bit     ov;
        if (!m_hold) begin
            if (c) begin
                m_acc    = 0;
                m_cnt    = 0;
                m_sticky = 0;
            end else if (v) begin
                full = m_acc + longint'(p);
                ov   = (full > ACC_MAX) || (full < ACC_MIN);
                next = full;
`ifdef NEURON_ACC_SAT_EN
                if (full > ACC_MAX) next = ACC_MAX;
                if (full < ACC_MIN) next = ACC_MIN;
`else
                if (full > ACC_MAX) next = full - ACC_SPAN;
                if (full < ACC_MIN) next = full + ACC_SPAN;
`endif
                if (m_cnt == N_TERMS - 1) begin
                    m_sum    = next;
                    m_ovf    = m_sticky | ov;
                    m_hold   = 1;
                    m_acc    = 0;
                    m_cnt    = 0;
                    m_sticky = 0;
                end else begin
                    m_acc    = next;
                    m_cnt    = m_cnt + 1;
                    m_sticky = m_sticky | ov;
                end
            end
        end else if (r) begin
            m_hold = 0;
            m_ovf  = 0;
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, return at negedge.
    task automatic applyStimulus(input bit v, input int p, input bit c, input bit r);
        ProductValid = v;
        ProductPort  = PROD_W'(p);
        Clear        = c;
        SumReady     = r;
        @(posedge clk);
        modelStep(v, p, c, r);
        @(negedge clk);
    endtask

    task automatic checkField(input string name, input longint got, input longint exp);
        n_compared++;
        if (got != exp) begin
            n_failed++;
            $display("[TB] FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // Compare every DUT output against the reference model.
    task automatic checkOutput(input string tag);
        checkField({tag, ".ProductReady"}, longint'(ProductReady), longint'(!m_hold));
        checkField({tag, ".SumValid"}, longint'(SumValid), longint'(m_hold));
        checkField({tag, ".SumOut"}, longint'($signed(SumOut)), m_sum);
        checkField({tag, ".Overflow"}, longint'(Overflow), longint'(m_ovf));
        checkField({tag, ".TermCount"}, longint'(TermCount), longint'(m_cnt));
    endtask

    // Compare every DUT output against a table row's hand-derived constants.
    task automatic checkVector(input string tag, input vec_t e);
        checkField({tag, ".ProductReady"}, longint'(ProductReady), longint'(e.e_ready));
        checkField({tag, ".SumValid"}, longint'(SumValid), longint'(e.e_valid));
        checkField({tag, ".SumOut"}, longint'($signed(SumOut)), longint'(e.e_sum));
        checkField({tag, ".Overflow"}, longint'(Overflow), longint'(e.e_ovf));
        checkField({tag, ".TermCount"}, longint'(TermCount), longint'(e.e_cnt));
    endtask

    function automatic vec_t mk(input bit v, input int p, input bit c, input bit r,
                                input bit er, input bit ev, input int es,
                                input bit eo, input int ec);
        vec_t t;
        t.v = v; t.p = p; t.c = c; t.r = r;
        t.e_ready = er; t.e_valid = ev; t.e_sum = es; t.e_ovf = eo; t.e_cnt = ec;
        return t;
    endfunction

    // Main test sequence.
    initial begin
        int sa;
        int sb;
        int p;
`ifdef NEURON_ACC_SAT_EN
        sa = 2048;
        sb = 4095;
`else
        sa = 4094;
        sb = -4092;
`endif
        // Overflow frame A: wraps/saturates twice, sticky flag reported.
        vecs.push_back(mk(1,  2047, 0, 1, 1, 0, 0,    0, 1));
        vecs.push_back(mk(1,  2047, 0, 1, 1, 0, 0,    0, 2));
        vecs.push_back(mk(1,  2047, 0, 1, 1, 0, 0,    0, 3));
        vecs.push_back(mk(1, -2047, 0, 1, 0, 1, sa,   1, 0));
        vecs.push_back(mk(0,     0, 0, 1, 1, 0, sa,   0, 0));
        // Overflow frame B: only the final add overflows.
        vecs.push_back(mk(1,  1000, 0, 1, 1, 0, sa,   0, 1));
        vecs.push_back(mk(1,  1000, 0, 1, 1, 0, sa,   0, 2));
        vecs.push_back(mk(1,  1000, 0, 1, 1, 0, sa,   0, 3));
        vecs.push_back(mk(1,  1100, 0, 1, 0, 1, sb,   1, 0));
        vecs.push_back(mk(0,     0, 0, 1, 1, 0, sb,   0, 0));
        // Basic frame: valid high for exactly one cycle, overflow clear.
        vecs.push_back(mk(1,  -666, 0, 1, 1, 0, sb,   0, 1));
        vecs.push_back(mk(1,  -198, 0, 1, 1, 0, sb,   0, 2));
        vecs.push_back(mk(1,   400, 0, 1, 1, 0, sb,   0, 3));
        vecs.push_back(mk(1,  2000, 0, 1, 0, 1, 1536, 0, 0));
        vecs.push_back(mk(0,     0, 0, 1, 1, 0, 1536, 0, 0));
        // Clear discards a partial frame and the product presented with it.
        vecs.push_back(mk(1,    10, 0, 1, 1, 0, 1536, 0, 1));
        vecs.push_back(mk(1,    20, 0, 1, 1, 0, 1536, 0, 2));
        vecs.push_back(mk(1,    30, 1, 1, 1, 0, 1536, 0, 0));
        vecs.push_back(mk(1,     1, 0, 1, 1, 0, 1536, 0, 1));
        vecs.push_back(mk(1,     2, 0, 1, 1, 0, 1536, 0, 2));
        vecs.push_back(mk(1,     3, 0, 1, 1, 0, 1536, 0, 3));
        vecs.push_back(mk(1,     4, 0, 0, 0, 1, 10,   0, 0));
        // Clear and a product in HOLD are ignored; sum held.
        vecs.push_back(mk(1,    99, 1, 0, 0, 1, 10,   0, 0));
        vecs.push_back(mk(0,     0, 0, 1, 1, 0, 10,   0, 0));

        GlobalReset  = 1'b0;
        ProductValid = 1'b0;
        ProductPort  = '0;
        Clear        = 1'b0;
        SumReady     = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        GlobalReset = 1'b1;
        checkOutput("reset");

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].v, vecs[i].p, vecs[i].c, vecs[i].r);
            checkVector($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure: sum held for 5 cycles, product pulses ignored.
        applyStimulus(1, -666, 0, 0);
        applyStimulus(1, -198, 0, 0);
        applyStimulus(1, 400, 0, 0);
        applyStimulus(1, 2000, 0, 0);
        checkOutput("bp_done");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(i[0], 77, 0, 0);
            checkOutput($sformatf("bp_hold%0d", i));
            checkField("bp_hold.SumOut_const", longint'($signed(SumOut)), 1536);
        end
        applyStimulus(0, 0, 0, 1);
        checkField("bp_release.TermCount", longint'(TermCount), 0);
        checkField("bp_release.ProductReady", longint'(ProductReady), 1);
        applyStimulus(1, 5, 0, 1);
        checkField("bp_next.TermCount", longint'(TermCount), 1);
        checkOutput("bp_next");

        // Async reset mid-frame (2 of 4 terms accepted already with the one above).
        applyStimulus(1, 5, 0, 1);
        #2 GlobalReset = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_mid");
        @(negedge clk);
        GlobalReset = 1'b1;
        checkField("rst_mid.ProductReady", longint'(ProductReady), 1);

        // Async reset during HOLD discards the pending sum.
        applyStimulus(1, 7, 0, 0);
        applyStimulus(1, 7, 0, 0);
        applyStimulus(1, 7, 0, 0);
        applyStimulus(1, 7, 0, 0);
        checkField("hold.SumValid", longint'(SumValid), 1);
        #2 GlobalReset = 1'b0;
        #1;
        modelReset();
        checkField("rst_hold.SumValid", longint'(SumValid), 0);
        checkField("rst_hold.SumOut", longint'($signed(SumOut)), 0);
        checkField("rst_hold.Overflow", longint'(Overflow), 0);
        checkField("rst_hold.TermCount", longint'(TermCount), 0);
        @(negedge clk);
        GlobalReset = 1'b1;
        checkOutput("rst_release");
        for (int i = 0; i < 4; i++) applyStimulus(1, 5, 0, 1);
        checkField("rst_frame.SumOut", longint'($signed(SumOut)), 20);
        checkField("rst_frame.SumValid", longint'(SumValid), 1);

        // Randomized traffic checked against the reference model.
        for (int i = 0; i < 600; i++) begin
            p = int'($signed(12'($urandom_range(0, 4095))));
            applyStimulus($urandom_range(0, 3) != 0, p,
                          $urandom_range(0, 24) == 0,
                          $urandom_range(0, 2) != 0);
            checkOutput($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule

// File: doc/neuron_accumulator.md
# neuron_accumulator

Consumes the stream of signed fixed-point products produced by the weight×pixel multiplier and sums them into one neuron pre-activation value per frame of `N_TERMS` products. Sits directly downstream of the multiplier and upstream of the activation/argmax logic. Applies valid/ready flow control on both sides, holds a completed sum until the consumer takes it, and flags accumulator overflow.

## Interface
Parameters:
- `PROD_W`, 26: product width, signed two's complement, same format as multiplier `Output_syn`.
- `ACC_W`, 32: accumulator and result width, signed; must be ≥ `PROD_W`.
- `N_TERMS`, 784: number of products per frame; must be ≥ 1.
- `CNT_W`, 10: counter width; must satisfy 2^`CNT_W` ≥ `N_TERMS`.

Ports:
- `clk` input 1: single clock; all logic is rising-edge.
- `GlobalReset` input 1: asynchronous, active-low reset.
- `ProductPort` input `PROD_W`: product value.
- `ProductValid` input 1: `ProductPort` holds a valid product.
- `ProductReady` output 1: the block can accept a product.
- `Clear` input 1: synchronous abort of the current frame.
- `SumOut` output `ACC_W`: completed frame sum, registered.
- `SumValid` output 1: `SumOut` is valid.
- `SumReady` input 1: the consumer accepts `SumOut`.
- `Overflow` output 1: an overflow occurred in the frame being presented.
- `TermCount` output `CNT_W`: number of products accepted in the current frame.

## Operation
- States: `ACCUM`, `HOLD`.
- `ACCUM`:
  - `ProductReady` = 1.
  - A product is accepted on a cycle where `ProductValid` and `ProductReady` are both high.
  - On accept: sign-extend the product to `ACC_W`, then `acc <= acc + ext(product)` and `TermCount++`.
- Last term: the accept with `TermCount == N_TERMS-1` causes all of the following on the same edge:
  - `SumOut <= acc + ext(product)`;
  - `SumValid <= 1`;
  - `Overflow` is set to the frame's sticky overflow, including an overflow caused by this final add;
  - `acc`, `TermCount` and the sticky flag clear to 0;
  - the state moves to `HOLD`.
- `HOLD`:
  - `ProductReady` = 0; no products are accepted.
  - `SumOut`, `SumValid` and `Overflow` stay stable until `SumReady` is high on a clock edge.
  - On that edge: `SumValid <= 0`, `Overflow <= 0`, and the state returns to `ACCUM`.
- Overflow detection: an add overflows when both operands have the same sign and the result's sign differs. This sets the frame's sticky flag.
- `Clear` in `ACCUM`:
  - `acc`, `TermCount` and the sticky flag go to 0.
  - A product presented on the same cycle is discarded.
  - `Clear` takes priority over accept.
- `Clear` in `HOLD`: ignored. The pending sum is never dropped.
- `N_TERMS` = 1: every accepted product completes a frame.

## Timing
- Reset (`GlobalReset` low, asynchronous) sets:
  - state `ACCUM`, `acc` = 0, `TermCount` = 0;
  - `SumOut` = 0, `SumValid` = 0, `Overflow` = 0;
  - `ProductReady` = 1 once reset releases.
- Reset in the middle of a frame or during `HOLD` discards the partial or pending sum.
- `ProductReady` is a combinational decode of the state register only. It has no combinational path from any input.
- Latency: last product accepted at edge t → `SumValid` = 1 after edge t.
- Throughput:
  - one product per cycle in `ACCUM`;
  - one bubble cycle per frame, spent in `HOLD`, when `SumReady` is held at 1;
  - the earliest first accept of the next frame is the edge after the `SumReady` handshake.
- `SumValid` may be high with `SumReady` already high: the handshake completes on the first edge of `HOLD`.

## Configuration
- `NEURON_ACC_SAT_EN` defined:
  - an overflowing add clamps to the most positive value (+2^(`ACC_W`-1)-1) on positive overflow, or to the most negative value (−2^(`ACC_W`-1)) on negative overflow;
  - the clamped value is stored and accumulation continues from it;
  - `Overflow` is still reported.
- `NEURON_ACC_SAT_EN` undefined:
  - two's-complement wrap-around;
  - `Overflow` is still reported.

## Test plan
- Basic frame: `N_TERMS`=4; feed −666, −198, 400, 2000 back-to-back; `SumReady`=1 → `SumValid` is high for exactly 1 cycle with `SumOut`=1536 and `Overflow`=0; `ProductReady` is low for that cycle.
- Backpressure: same frame, `SumReady`=0 for 5 cycles → `SumOut`/`SumValid` are held; `ProductReady`=0 and `ProductValid` pulses are not counted; on release, the next frame starts at `TermCount`=0.
- Clear: `N_TERMS`=4; feed 10, 20; assert `Clear` together with a third product of 30; then feed 1, 2, 3, 4 → `SumOut`=10.
- Overflow: `ACC_W`=26, `N_TERMS`=2; feed 2^25−1, then 1 → `Overflow`=1; `SumOut`=2^25−1 with the macro defined, −2^25 without it.
- Async reset: assert `GlobalReset`=0 mid-frame (2 of 4 terms) and during `HOLD` → all outputs go to 0 immediately and `TermCount`=0; after release, a full frame of 5, 5, 5, 5 gives `SumOut`=20.
